// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Radix-2 restoring DIV/DIVU sequencer for EX, {HI,LO} result with
//            start/ready handshake. Optional macro: DIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*DATA_W:0]      work_q;
    logic [2*DATA_W:0]      work_d;
    logic [DATA_W-1:0]      divisor_q;
    logic                   sign_quo_q;
    logic                   sign_rem_q;
    logic [2*DATA_W-1:0]    result_q;
    logic                   ready_q;

    logic [DATA_W-1:0]      mag1;
    logic [DATA_W-1:0]      mag2;
    logic [DATA_W:0]        minuend;
    logic [DATA_W:0]        diff;
    logic [DATA_W-1:0]      quo_fix;
    logic [DATA_W-1:0]      rem_fix;

    // work_q = {partial remainder, remaining dividend bits, quotient bits};
    // the top DATA_W+1 bits are always the already-shifted trial minuend.
    always_comb begin
        mag1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        minuend = work_q[2*DATA_W:DATA_W];
        diff    = minuend - {1'b0, divisor_q};
        if (diff[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
        end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
        end
        quo_fix = sign_quo_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
        rem_fix = sign_rem_q ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (start_i && !annul_i) begin
                        divisor_q  <= mag2;
                        work_q     <= {{DATA_W{1'b0}}, mag1, 1'b0};
                        sign_quo_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        sign_rem_q <= signed_div_i & opdata1_i[DATA_W-1];
                        cnt_q      <= '0;
                        if (opdata2_i == '0) begin
                            state_q <= S_BYZERO;
`ifdef DIV_EARLY_OUT_EN
                        end else if (mag1 < mag2) begin
                            // Quotient is zero; remainder is the dividend as given.
                            state_q  <= S_END;
                            result_q <= {opdata1_i, {DATA_W{1'b0}}};
                            ready_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_ON;
                        end
                    end
                end
                S_BYZERO: begin
                    result_q <= '0;
                    if (annul_i) begin
                        state_q <= S_FREE;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= S_END;
                        ready_q <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q  <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q  <= S_END;
                        ready_q  <= 1'b1;
                        result_q <= {rem_fix, quo_fix};
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_END: begin
                    if (!start_i || annul_i) begin
                        state_q  <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q  <= S_FREE;
                    ready_q  <= 1'b0;
                    result_q <= '0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q != S_FREE);

endmodule
`default_nettype wire
